ldpc_ber_tester_err_stats: RTL and testbench

Parametrised bit-error statistics engine for the LDPC BER tester, sitting downstream of the decoder-output XOR stage on the `s_axis_dout` stream. It counts set bits (bit errors) over a campaign of `frame_target` frames, masking the final beat of each frame with `last_mask`. It keeps saturating per-campaign and per-frame statistics, and runs a start/drain/done state machine so software can read stable results.

---
 rtl/ldpc_ber_tester_err_stats.sv | 170 +++++++++++++++++
 tb/tb_ldpc_ber_tester_err_stats.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_ber_tester_err_stats.sv
// ldpc_ber_tester_err_stats: campaign bit-error statistics with a 3-stage popcount pipeline.
// Per-frame statistics are built only when LDPC_BER_TESTER_FRAME_STATS_EN is defined.
module ldpc_ber_tester_err_stats #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 48,
  parameter int FRM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRM_WIDTH-1:0]  frame_target,
  input  logic [DATA_WIDTH-1:0] last_mask,
  input  logic [DATA_WIDTH-1:0] s_axis_dout_tdata,
  input  logic                  s_axis_dout_tvalid,
  output logic                  s_axis_dout_tready,
  input  logic                  s_axis_dout_tlast,
  output logic [CNT_WIDTH-1:0]  bit_errors,
  output logic                  bit_errors_sat,
  output logic [FRM_WIDTH-1:0]  frame_count,
  output logic [FRM_WIDTH-1:0]  frame_errors,
  output logic [15:0]           max_frame_errors,
  output logic [15:0]           last_frame_errors,
  output logic                  active,
  output logic                  done
);
  localparam int NW  = DATA_WIDTH / 32;
  localparam int SW  = $clog2(DATA_WIDTH + 1);
  localparam int CW1 = CNT_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic tready_q, tready_d;
  logic [FRM_WIDTH-1:0] acc_frames_q, acc_frames_d;
  logic [NW-1:0][5:0] p1_q, p1_d;
  logic s1_v_q, s1_v_d, s1_l_q, s1_l_d;
  logic [SW-1:0] sum_q, sum_d;
  logic s2_v_q, s2_v_d, s2_l_q, s2_l_d;
  logic [CNT_WIDTH-1:0] bit_errors_q, bit_errors_d;
  logic sat_q, sat_d;
  logic [FRM_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] beat;
  logic [CNT_WIDTH:0] be_sum;
  logic hs, clr;
  always_comb begin
    beat = s_axis_dout_tlast ? s_axis_dout_tdata & last_mask : s_axis_dout_tdata;
    for (int w = 0; w < NW; w++) begin
      p1_d[w] = '0;
      for (int b = 0; b < 32; b++) p1_d[w] = p1_d[w] + 6'(beat[w*32+b]);
    end
    sum_d = '0;
    for (int w = 0; w < NW; w++) sum_d = sum_d + SW'(p1_q[w]);
  end
  always_comb begin
    hs = s_axis_dout_tvalid & tready_q;
    clr = start & (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    tready_d = tready_q;
    acc_frames_d = acc_frames_q;
    s1_v_d = hs;
    s1_l_d = s_axis_dout_tlast;
    s2_v_d = s1_v_q;
    s2_l_d = s1_l_q;
    be_sum = {1'b0, bit_errors_q} + CW1'(sum_q);
    bit_errors_d = bit_errors_q;
    sat_d = sat_q;
    frame_count_d = frame_count_q;
    if (clr) begin
      state_d = RUN;
      tready_d = 1'b1;
      acc_frames_d = '0;
      bit_errors_d = '0;
      sat_d = 1'b0;
      frame_count_d = '0;
    end else begin
      if (hs && s_axis_dout_tlast) begin
        acc_frames_d = acc_frames_q + 1'b1;
        if (|frame_target && acc_frames_d == frame_target) begin
          state_d = DRAIN;
          tready_d = 1'b0;
        end
      end
      if (state_q == DRAIN && !s1_v_q && !s2_v_q) state_d = DONE;
      if (s2_v_q) begin
        bit_errors_d = be_sum[CNT_WIDTH] ? '1 : be_sum[CNT_WIDTH-1:0];
        sat_d = sat_q | be_sum[CNT_WIDTH];
        frame_count_d = s2_l_q ? frame_count_q + 1'b1 : frame_count_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tready_q <= 1'b0;
      acc_frames_q <= '0;
      p1_q <= '0;
      s1_v_q <= 1'b0;
      s1_l_q <= 1'b0;
      sum_q <= '0;
      s2_v_q <= 1'b0;
      s2_l_q <= 1'b0;
      bit_errors_q <= '0;
      sat_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      tready_q <= tready_d;
      acc_frames_q <= acc_frames_d;
      p1_q <= p1_d;
      s1_v_q <= s1_v_d;
      s1_l_q <= s1_l_d;
      sum_q <= sum_d;
      s2_v_q <= s2_v_d;
      s2_l_q <= s2_l_d;
      bit_errors_q <= bit_errors_d;
      sat_q <= sat_d;
      frame_count_q <= frame_count_d;
    end
  end
`ifdef LDPC_BER_TESTER_FRAME_STATS_EN
  logic [15:0] facc_q, facc_d, max_q, max_d, lastf_q, lastf_d, tot_s;
  logic [FRM_WIDTH-1:0] ferr_q, ferr_d;
  logic [16:0] tot;
  always_comb begin
    tot = {1'b0, facc_q} + 17'(sum_q);
    tot_s = tot[16] ? 16'hffff : tot[15:0];
    facc_d = facc_q;
    max_d = max_q;
    lastf_d = lastf_q;
    ferr_d = ferr_q;
    if (clr) begin
      facc_d = '0;
      max_d = '0;
      lastf_d = '0;
      ferr_d = '0;
    end else if (s2_v_q) begin
      facc_d = s2_l_q ? '0 : tot_s;
      if (s2_l_q) begin
        lastf_d = tot_s;
        max_d = tot_s > max_q ? tot_s : max_q;
        ferr_d = ferr_q + FRM_WIDTH'(tot_s != 16'd0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      facc_q <= '0;
      max_q <= '0;
      lastf_q <= '0;
      ferr_q <= '0;
    end else begin
      facc_q <= facc_d;
      max_q <= max_d;
      lastf_q <= lastf_d;
      ferr_q <= ferr_d;
    end
  end
  assign frame_errors = ferr_q;
  assign max_frame_errors = max_q;
  assign last_frame_errors = lastf_q;
`else
  assign frame_errors = '0;
  assign max_frame_errors = '0;
  assign last_frame_errors = '0;
`endif
  assign s_axis_dout_tready = tready_q;
  assign bit_errors = bit_errors_q;
  assign bit_errors_sat = sat_q;
  assign frame_count = frame_count_q;
  assign active = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_ldpc_ber_tester_err_stats.sv
// tb_ldpc_ber_tester_err_stats: randomized bench against a frame-level reference model;
// a second instance with an 8-bit accumulator exercises saturation.
module tb_ldpc_ber_tester_err_stats;
  localparam int DW = 128, CW = 48, FW = 32;
  typedef struct {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, tvalid = 1'b0, tlast = 1'b0;
  logic [FW-1:0] frame_target = '0;
  logic [DW-1:0] last_mask = '0, tdata = '0;
  logic tready, be_sat, active, done;
  logic [CW-1:0] be;
  logic [FW-1:0] fc, fe;
  logic [15:0] mfe, lfe;
  logic s_tready, s_sat, s_active, s_done;
  logic [7:0] s_be;
  logic [FW-1:0] s_fc, s_fe;
  logic [15:0] s_mfe, s_lfe;
  int errors = 0, checks = 0;
  beat_t q[$];
  always #5 clk = ~clk;
  ldpc_ber_tester_err_stats u_dut (
    .clk(clk), .reset(reset), .start(start), .frame_target(frame_target), .last_mask(last_mask),
    .s_axis_dout_tdata(tdata), .s_axis_dout_tvalid(tvalid), .s_axis_dout_tready(tready),
    .s_axis_dout_tlast(tlast), .bit_errors(be), .bit_errors_sat(be_sat), .frame_count(fc),
    .frame_errors(fe), .max_frame_errors(mfe), .last_frame_errors(lfe), .active(active), .done(done));
  ldpc_ber_tester_err_stats #(.CNT_WIDTH(8)) u_sat (
    .clk(clk), .reset(reset), .start(start), .frame_target(frame_target), .last_mask(last_mask),
    .s_axis_dout_tdata(tdata), .s_axis_dout_tvalid(tvalid), .s_axis_dout_tready(s_tready),
    .s_axis_dout_tlast(tlast), .bit_errors(s_be), .bit_errors_sat(s_sat), .frame_count(s_fc),
    .frame_errors(s_fe), .max_frame_errors(s_mfe), .last_frame_errors(s_lfe), .active(s_active),
    .done(s_done));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [DW-1:0] ones(input int n, input int off);
    logic [DW-1:0] v = '0;
    for (int k = 0; k < n; k++) v[off+k] = 1'b1;
    return v;
  endfunction
  task automatic add(input logic [DW-1:0] d, input logic l);
    q.push_back('{d, l});
  endtask
  task automatic model(input logic [DW-1:0] mask, output longint ebe, output int efc, efe, emx, elf);
    longint acc = 0;
    int c;
    ebe = 0; efc = 0; efe = 0; emx = 0; elf = 0;
    foreach (q[i]) begin
      c = $countones(q[i].l ? q[i].d & mask : q[i].d);
      ebe += c;
      acc = (acc + c > 65535) ? 65535 : acc + c;
      if (q[i].l) begin
        elf = int'(acc);
        if (acc > emx) emx = int'(acc);
        if (acc != 0) efe++;
        efc++;
        acc = 0;
      end
    end
`ifndef LDPC_BER_TESTER_FRAME_STATS_EN
    efe = 0; emx = 0; elf = 0;
`endif
  endtask
  task automatic test_campaign(input int target, input int gap, input string name);
    longint ebe;
    int efc, efe, emx, elf, i, budget, extra;
    logic go, hs;
    logic [7:0] esat;
    model(last_mask, ebe, efc, efe, emx, elf);
    esat = ebe > 255 ? 8'hff : 8'(ebe);
    frame_target = FW'(target);
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (tready !== 1'b1 || active !== 1'b1 || done !== 1'b0)
      $display("FAIL %s start: tready/active/done got %b%b%b want 110", name, tready, active, done);
    i = 0;
    budget = 0;
    while (i < q.size() && budget < 4000) begin
      go = $urandom_range(99) >= gap;
      tvalid = go;
      tdata = go ? q[i].d : {4{$urandom}};
      tlast = go ? q[i].l : 1'($urandom_range(1));
      hs = go && tready;
      tick;
      if (hs) i++;
      budget++;
    end
    checks++;
    if (i != q.size()) begin
      errors++;
      $display("FAIL %s accept: beats got %0d want %0d", name, i, q.size());
    end
    tvalid = 1'b1; tdata = '1; tlast = 1'b1; extra = 0;
    checks++;
    if (tready !== 1'b0 || active !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s after_last: tready/active/done got %b%b%b want 010", name, tready, active, done);
    end
    for (int k = 0; k < 2; k++) begin
      if (tready) extra++;
      tick;
    end
    checks++;
    if (done !== 1'b0 || be !== CW'(ebe)) begin
      errors++;
      $display("FAIL %s n_plus_3: done=%b bit_errors=%0d want done=0 bit_errors=%0d", name, done, be, ebe);
    end
    if (tready) extra++;
    tick;
    checks++;
    if (done !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done/active got %b%b want 10", name, done, active);
    end
    for (int k = 0; k < 4; k++) begin
      if (tready) extra++;
      tick;
    end
    tvalid = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s no_extra_hs: got %0d want 0", name, extra);
    end
    checks++;
    if (be !== CW'(ebe)) begin errors++; $display("FAIL %s bit_errors: got %0d want %0d", name, be, ebe); end
    checks++;
    if (fc !== FW'(efc)) begin errors++; $display("FAIL %s frame_count: got %0d want %0d", name, fc, efc); end
    checks++;
    if (fe !== FW'(efe)) begin errors++; $display("FAIL %s frame_errors: got %0d want %0d", name, fe, efe); end
    checks++;
    if (mfe !== 16'(emx)) begin errors++; $display("FAIL %s max_frame_errors: got %0d want %0d", name, mfe, emx); end
    checks++;
    if (lfe !== 16'(elf)) begin errors++; $display("FAIL %s last_frame_errors: got %0d want %0d", name, lfe, elf); end
    checks++;
    if (be_sat !== 1'b0) begin errors++; $display("FAIL %s bit_errors_sat: got %b want 0", name, be_sat); end
    checks++;
    if (s_be !== esat || s_sat !== (ebe > 255)) begin
      errors++;
      $display("FAIL %s narrow_acc: got %0d/%b want %0d/%b", name, s_be, s_sat, esat, ebe > 255);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    checks++;
    if ({tready, active, done, be_sat, be, fc, fe, mfe, lfe} !== '0 ||
        {s_tready, s_active, s_done, s_sat, s_be, s_fc, s_fe, s_mfe, s_lfe} !== '0) begin
      errors++;
      $display("FAIL reset_state: tready=%b active=%b done=%b be=%0d fc=%0d want all 0", tready, active, done, be, fc);
    end
  endtask
  task automatic test_single_frame;
    q.delete();
    last_mask = 128'hff;
    add('1, 1'b0);
    add('0, 1'b0);
    add('1, 1'b1);
    test_campaign(1, 0, "single_frame");
  endtask
  task automatic build_multi;
    logic [DW-1:0] junk = ones(8, 120);
    q.delete();
    last_mask = ~junk;
    add('0, 1'b0); add(junk, 1'b1);
    add(ones(3, 10), 1'b0); add(ones(2, 40) | junk, 1'b1);
    add(junk, 1'b1);
    add(ones(4, 0), 1'b0); add(ones(4, 64), 1'b0); add(ones(4, 100) | junk, 1'b1);
  endtask
  task automatic test_multi_frame;
    build_multi;
    test_campaign(4, 0, "multi_frame");
  endtask
  task automatic test_bubbles;
    build_multi;
    test_campaign(4, 40, "bubbles");
  endtask
  task automatic test_random;
    int nf, nb;
    for (int r = 0; r < 3; r++) begin
      q.delete();
      nf = $urandom_range(5, 2);
      for (int f = 0; f < nf; f++) begin
        nb = $urandom_range(3, 1);
        for (int b = 0; b < nb; b++)
          add({4{$urandom}} & {4{$urandom}} & {4{$urandom}} & ((f == 1) ? '0 : '1), b == nb - 1);
      end
      last_mask = {4{$urandom}};
      test_campaign(nf, 10 * r, "random");
    end
  endtask
  task automatic test_saturation;
    frame_target = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tvalid = 1'b1; tdata = '1; tlast = 1'b0;
    repeat (3) tick;
    tvalid = 1'b0;
    repeat (4) tick;
    checks++;
    if (s_be !== 8'hff || s_sat !== 1'b1 || be !== CW'(384) || be_sat !== 1'b0) begin
      errors++;
      $display("FAIL saturation: narrow=%0d/%b wide=%0d/%b want 255/1 384/0", s_be, s_sat, be, be_sat);
    end
    checks++;
    if (active !== 1'b1 || done !== 1'b0 || tready !== 1'b1) begin
      errors++;
      $display("FAIL sat_run: active/done/tready got %b%b%b want 101", active, done, tready);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    checks++;
    if (be !== CW'(384) || active !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: bit_errors=%0d active=%b want 384 1", be, active);
    end
  endtask
  task automatic test_reset_restart;
    tvalid = 1'b1; tdata = ones(9, 0); tlast = 1'b0;
    tick;
    tvalid = 1'b0;
    reset = 1'b1;
    tick;
    checks++;
    if ({tready, active, done, be_sat, be, fc, fe, mfe, lfe} !== '0 || {s_sat, s_be} !== '0) begin
      errors++;
      $display("FAIL reset_mid: tready=%b active=%b be=%0d sat=%b want all 0", tready, active, be, s_sat);
    end
    reset = 1'b0;
    repeat (4) tick;
    checks++;
    if (be !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: bit_errors=%0d active=%b want 0 0", be, active);
    end
    q.delete();
    last_mask = '1;
    add(ones(7, 50), 1'b1);
    test_campaign(1, 0, "restart");
  endtask
  initial begin
    test_reset;
    test_single_frame;
    test_multi_frame;
    test_bubbles;
    test_random;
    test_saturation;
    test_reset_restart;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
